// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl.
// The master is the bench or producer/consumer pair; the slave is the sequencer.
interface nibble_serial_add_ctrl_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two W-bit operands one nibble per clock through an external 4-bit CLA,
// chaining carry-out to carry-in, and returns {cout, sum} over valid/ready.
//
//   state  | meaning
//   S_IDLE | waiting for an operand set, in_ready high
//   S_RUN  | one nibble per edge through the CLA, LSB first
//   S_DONE | result held with out_valid until out_ready
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  nibble_serial_add_ctrl_if.slave       bus,
  output logic                          busy,
  output logic [3:0]                    add_a,
  output logic [3:0]                    add_b,
  output logic                          add_cin,
  input  logic [3:0]                    add_sum,
  input  logic                          add_cout
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [W-1:0]     r_res;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDX_W-1:0] r_idx;
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [W-1:0]     w_res_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    add_a         = 4'd0;
    add_b         = 4'd0;
    add_cin       = 1'b0;
    w_accept      = 1'b0;
    w_step        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // in_ready is masked by rst_n so nothing looks accepted during reset
        bus.in_ready = rst_n;
        w_accept     = rst_n & bus.in_valid;
        if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        add_a   = r_a_sh[3:0];
        add_b   = r_b_sh[3:0];
        add_cin = r_carry;
        w_step  = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_last = (r_idx == LAST_IDX);

  always_comb begin
    w_res_nxt                 = r_res;
    w_res_nxt[4*r_idx +: 4]   = add_sum;
  end

  // r_res is the working accumulator; r_sum only changes when a result completes,
  // so the published sum stays put through the next operation's RUN phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_carry <= bus.cin;
      r_idx   <= '0;
      r_res   <= '0;
    end else if (w_step) begin
      r_res   <= w_res_nxt;
      r_carry <= add_cout;
      r_a_sh  <= r_a_sh >> 4;
      r_b_sh  <= r_b_sh >> 4;
      if (w_last) begin
        r_sum  <= w_res_nxt;
        r_cout <= add_cout;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl at NIBBLES = 4, 1 and 16 with an arithmetic
// reference model checked every cycle plus directed literal expectations.
module tb_nibble_serial_add_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // per-instance stimulus (0: N=4, 1: N=1, 2: N=16)
  logic        t_rst [3];
  logic        t_iv  [3];
  logic [63:0] t_a   [3];
  logic [63:0] t_b   [3];
  logic        t_cin [3];
  logic        t_or  [3];

  // per-instance observed outputs, zero-extended
  logic        d_ir   [3];
  logic        d_ov   [3];
  logic [63:0] d_sum  [3];
  logic        d_cout [3];
  logic        d_busy [3];
  logic [3:0]  d_adda [3];
  logic [3:0]  d_addb [3];
  logic        d_addc [3];

  int n_pass  = 0;
  int n_total = 0;

  nibble_serial_add_ctrl_if #(.NIBBLES(4))  if4();
  nibble_serial_add_ctrl_if #(.NIBBLES(1))  if1();
  nibble_serial_add_ctrl_if #(.NIBBLES(16)) if16();

  logic [3:0] aa4, ab4, as4, aa1, ab1, as1, aa16, ab16, as16;
  logic       ac4, aco4, ac1, aco1, ac16, aco16;
  logic       busy4, busy1, busy16;

  // behavioural 4-bit adders standing in for the CLA
  assign {aco4,  as4}  = 5'(aa4)  + 5'(ab4)  + 5'(ac4);
  assign {aco1,  as1}  = 5'(aa1)  + 5'(ab1)  + 5'(ac1);
  assign {aco16, as16} = 5'(aa16) + 5'(ab16) + 5'(ac16);

  nibble_serial_add_ctrl #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst_n(t_rst[0]), .bus(if4), .busy(busy4),
    .add_a(aa4), .add_b(ab4), .add_cin(ac4), .add_sum(as4), .add_cout(aco4));
  nibble_serial_add_ctrl #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(t_rst[1]), .bus(if1), .busy(busy1),
    .add_a(aa1), .add_b(ab1), .add_cin(ac1), .add_sum(as1), .add_cout(aco1));
  nibble_serial_add_ctrl #(.NIBBLES(16)) u_dut16 (
    .clk(clk), .rst_n(t_rst[2]), .bus(if16), .busy(busy16),
    .add_a(aa16), .add_b(ab16), .add_cin(ac16), .add_sum(as16), .add_cout(aco16));

  assign if4.in_valid  = t_iv[0];  assign if4.a  = t_a[0][15:0]; assign if4.b  = t_b[0][15:0];
  assign if4.cin       = t_cin[0]; assign if4.out_ready  = t_or[0];
  assign if1.in_valid  = t_iv[1];  assign if1.a  = t_a[1][3:0];  assign if1.b  = t_b[1][3:0];
  assign if1.cin       = t_cin[1]; assign if1.out_ready  = t_or[1];
  assign if16.in_valid = t_iv[2];  assign if16.a = t_a[2];       assign if16.b = t_b[2];
  assign if16.cin      = t_cin[2]; assign if16.out_ready = t_or[2];

  assign d_ir[0] = if4.in_ready;  assign d_ov[0] = if4.out_valid;  assign d_sum[0] = 64'(if4.sum);
  assign d_ir[1] = if1.in_ready;  assign d_ov[1] = if1.out_valid;  assign d_sum[1] = 64'(if1.sum);
  assign d_ir[2] = if16.in_ready; assign d_ov[2] = if16.out_valid; assign d_sum[2] = if16.sum;
  assign d_cout[0] = if4.cout; assign d_cout[1] = if1.cout; assign d_cout[2] = if16.cout;
  assign d_busy[0] = busy4;    assign d_busy[1] = busy1;    assign d_busy[2] = busy16;
  assign d_adda[0] = aa4; assign d_adda[1] = aa1; assign d_adda[2] = aa16;
  assign d_addb[0] = ab4; assign d_addb[1] = ab1; assign d_addb[2] = ab16;
  assign d_addc[0] = ac4; assign d_addc[1] = ac1; assign d_addc[2] = ac16;

  function automatic int nib(int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 16);
  endfunction

  function automatic logic [63:0] wmask(int n);
    return (n >= 16) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (4 * n)) - 64'd1);
  endfunction

  task automatic chk(string nm, int inst, logic [64:0] act, logic [64:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
  endtask

  // ---------------- reference model: transaction-level view ----------------
  bit          m_init  [3];
  bit          m_idle  [3];
  int          m_cnt   [3];
  bit          m_valid [3];
  logic [63:0] m_sum   [3];
  bit          m_cout  [3];
  logic [63:0] m_a     [3];
  logic [63:0] m_b     [3];
  bit          m_cin   [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [65:0] full;
      if (!t_rst[i]) begin
        m_init[i] = 1; m_idle[i] = 1; m_cnt[i] = 0; m_valid[i] = 0;
        m_sum[i] = '0; m_cout[i] = 0;
      end else if (m_init[i]) begin
        if (m_idle[i] && t_iv[i]) begin
          m_idle[i] = 0; m_cnt[i] = nib(i);
          m_a[i] = t_a[i] & wmask(nib(i)); m_b[i] = t_b[i] & wmask(nib(i)); m_cin[i] = t_cin[i];
        end else if (m_cnt[i] > 0) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            full = 66'(m_a[i]) + 66'(m_b[i]) + 66'(m_cin[i]);
            m_valid[i] = 1;
            m_sum[i]   = full[63:0] & wmask(nib(i));
            m_cout[i]  = full[4 * nib(i)];
          end
        end else if (m_valid[i] && t_or[i]) begin
          m_valid[i] = 0; m_idle[i] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_init[i]) begin
        int          k;
        logic [63:0] lm;
        logic [65:0] part;
        logic [3:0]  ea, eb;
        logic        ec;
        ea = 4'd0; eb = 4'd0; ec = 1'b0;
        if (m_cnt[i] > 0) begin
          k    = nib(i) - m_cnt[i];
          lm   = (k == 0) ? 64'd0 : wmask(k);
          part = 66'(m_a[i] & lm) + 66'(m_b[i] & lm) + 66'(m_cin[i]);
          ea   = 4'((m_a[i] >> (4 * k)) & 64'hF);
          eb   = 4'((m_b[i] >> (4 * k)) & 64'hF);
          ec   = part[4 * k];
        end
        chk("in_ready",  i, 65'(d_ir[i]),   65'(m_idle[i] && t_rst[i]));
        chk("out_valid", i, 65'(d_ov[i]),   65'(m_valid[i]));
        chk("busy",      i, 65'(d_busy[i]), 65'(!m_idle[i]));
        chk("sum",       i, 65'(d_sum[i]),  65'(m_sum[i]));
        chk("cout",      i, 65'(d_cout[i]), 65'(m_cout[i]));
        chk("add_a",     i, 65'(d_adda[i]), 65'(ea));
        chk("add_b",     i, 65'(d_addb[i]), 65'(eb));
        chk("add_cin",   i, 65'(d_addc[i]), 65'(ec));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic offer(int i, logic [63:0] a, logic [63:0] b, logic c);
    bit ok;
    ok = 0;
    t_a[i] = a; t_b[i] = b; t_cin[i] = c; t_iv[i] = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_ir[i]) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    t_iv[i] = 0;
    if (!ok) chk("accept_timeout", i, 65'd0, 65'd1);
  endtask

  task automatic wait_valid(int i, int max, output int lat);
    lat = 0;
    for (int k = 1; k <= max; k++) begin
      @(posedge clk); #1;
      if (d_ov[i]) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) chk("valid_timeout", i, 65'd0, 65'd1);
  endtask

  task automatic dir4();
    int          lat;
    int          cyc;
    logic [3:0]  rec_a [4];
    logic        rec_c [4];
    logic [63:0] first_sum;

    // carry ripple through every nibble
    t_or[0] = 0;
    offer(0, 64'hFFFF, 64'h0001, 0);
    wait_valid(0, 20, lat);
    chk("ripple_latency", 0, 65'(lat), 65'd4);
    chk("ripple_sum",     0, 65'(d_sum[0]), 65'h0000);
    chk("ripple_cout",    0, 65'(d_cout[0]), 65'd1);
    t_or[0] = 1; @(posedge clk); #1; t_or[0] = 0;

    // carry-in use and presented nibble sequence
    offer(0, 64'h1234, 64'h4321, 1);
    for (int j = 0; j < 4; j++) begin
      rec_a[j] = d_adda[0]; rec_c[j] = d_addc[0];
      @(posedge clk); #1;
    end
    chk("cin_add_a0", 0, 65'(rec_a[0]), 65'd4);
    chk("cin_add_a1", 0, 65'(rec_a[1]), 65'd3);
    chk("cin_add_a2", 0, 65'(rec_a[2]), 65'd2);
    chk("cin_add_a3", 0, 65'(rec_a[3]), 65'd1);
    chk("cin_add_c0", 0, 65'(rec_c[0]), 65'd1);
    chk("cin_add_c1", 0, 65'(rec_c[1]), 65'd0);
    chk("cin_add_c2", 0, 65'(rec_c[2]), 65'd0);
    chk("cin_add_c3", 0, 65'(rec_c[3]), 65'd0);
    chk("cin_valid",  0, 65'(d_ov[0]), 65'd1);
    chk("cin_sum",    0, 65'(d_sum[0]), 65'h5556);
    chk("cin_cout",   0, 65'(d_cout[0]), 65'd0);
    t_or[0] = 1; @(posedge clk); #1; t_or[0] = 0;

    // MSB carry-out then backpressure
    offer(0, 64'h8000, 64'h8000, 0);
    wait_valid(0, 20, lat);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("hold_valid",    0, 65'(d_ov[0]), 65'd1);
      chk("hold_sum",      0, 65'(d_sum[0]), 65'h0000);
      chk("hold_cout",     0, 65'(d_cout[0]), 65'd1);
      chk("hold_in_ready", 0, 65'(d_ir[0]), 65'd0);
    end
    @(posedge clk); #1; t_or[0] = 1;
    @(posedge clk); #1; t_or[0] = 0;
    chk("release_in_ready", 0, 65'(d_ir[0]), 65'd1);

    // operand offered while busy is held until IDLE
    t_or[0] = 1;
    offer(0, 64'h1000, 64'h0010, 0);
    t_a[0] = 64'h0F0F; t_b[0] = 64'h0101; t_cin[0] = 0; t_iv[0] = 1;
    cyc = 0; first_sum = '1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (d_ov[0]) first_sum = d_sum[0];
      if (d_ir[0]) begin
        @(posedge clk); #1;
        cyc = k;
        break;
      end
    end
    t_iv[0] = 0;
    chk("b2b_accept_gap", 0, 65'(cyc), 65'd6);
    chk("b2b_first_sum",  0, 65'(first_sum), 65'h1010);
    wait_valid(0, 20, lat);
    chk("b2b_second_sum", 0, 65'(d_sum[0]), 65'h1010);
    chk("b2b_second_lat", 0, 65'(lat), 65'd4);
    @(posedge clk); #1; t_or[0] = 0;

    // reset two cycles after accept aborts the operation
    offer(0, 64'hFFFF, 64'hFFFF, 1);
    @(posedge clk); #1;
    t_rst[0] = 0;
    @(negedge clk);
    chk("rst_in_ready", 0, 65'(d_ir[0]), 65'd0);
    @(posedge clk); #1;
    t_rst[0] = 1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("abort_no_valid", 0, 65'(d_ov[0]), 65'd0);
    end
    chk("abort_sum",  0, 65'(d_sum[0]), 65'h0000);
    chk("abort_cout", 0, 65'(d_cout[0]), 65'd0);
    t_or[0] = 1;
    offer(0, 64'h0001, 64'h0001, 0);
    wait_valid(0, 20, lat);
    chk("after_abort_sum", 0, 65'(d_sum[0]), 65'h0002);
    @(posedge clk); #1; t_or[0] = 0;
  endtask

  task automatic rnd_run(int i, int nops);
    int done;
    int lat;
    bit acc, xfer;

    t_or[i] = 0;
    if (i == 1) offer(i, 64'hF, 64'h1, 0);
    else        offer(i, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0);
    wait_valid(i, 40, lat);
    chk("corner_latency", i, 65'(lat), 65'(nib(i)));
    chk("corner_sum",     i, 65'(d_sum[i]), 65'd0);
    chk("corner_cout",    i, 65'(d_cout[i]), 65'd1);
    t_or[i] = 1; @(posedge clk); #1; t_or[i] = 0;

    done = 0;
    t_a[i] = {$urandom, $urandom}; t_b[i] = {$urandom, $urandom}; t_cin[i] = 1'($urandom);
    t_iv[i] = 1;
    for (int cyc = 0; cyc < 40000 && done < nops; cyc++) begin
      @(negedge clk);
      acc  = t_iv[i] && d_ir[i];
      xfer = d_ov[i] && t_or[i];
      @(posedge clk); #1;
      if (xfer) done++;
      if (acc) begin
        t_a[i] = {$urandom, $urandom}; t_b[i] = {$urandom, $urandom}; t_cin[i] = 1'($urandom);
        t_iv[i] = ($urandom_range(0, 3) != 0);
      end else if (!t_iv[i]) begin
        t_iv[i] = 1'($urandom_range(0, 1));
      end
      t_or[i] = ($urandom_range(0, 3) != 0);
    end
    t_iv[i] = 0;
    chk("random_ops_done", i, 65'(done), 65'(nops));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      t_rst[i] = 0; t_iv[i] = 0; t_a[i] = '0; t_b[i] = '0; t_cin[i] = 0; t_or[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset_in_ready_low", i, 65'(d_ir[i]), 65'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) t_rst[i] = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_in_ready", i, 65'(d_ir[i]), 65'd1);
      chk("post_reset_sum",      i, 65'(d_sum[i]), 65'd0);
      chk("post_reset_busy",     i, 65'(d_busy[i]), 65'd0);
    end
    @(posedge clk); #1;

    fork
      dir4();
      rnd_run(1, 1000);
      rnd_run(2, 1000);
    join

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
